// File: rtl/wrf_pkt_gen.sv
// WR-fabric frame generator: emits broadcast Ethernet frames with a seeded
// LFSR payload on a 16-bit pipelined fabric and counts completed/aborted frames.
module wrf_pkt_gen #(
    parameter logic [47:0] g_src_mac     = 48'h010203040506,
    parameter int unsigned g_ack_timeout = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_en_i,
    input  logic [10:0] cfg_len_i,
    input  logic [15:0] cfg_gap_i,
    input  logic [15:0] cfg_num_i,
    input  logic [15:0] cfg_seed_i,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [1:0]  src_adr_o,
    output logic [1:0]  src_sel_o,
    output logic [15:0] src_dat_o,
    input  logic        src_stall_i,
    input  logic        src_ack_i,
    input  logic        src_err_i,
    output logic        busy_o,
    output logic [31:0] frames_o,
    output logic [31:0] errs_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_WACK = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int unsigned TMO_W    = $clog2(g_ack_timeout + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(g_ack_timeout - 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;   // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    // One step of the right-shifting Galois LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0]) begin
            return (v >> 1) ^ LFSR_MASK;
        end else begin
            return v >> 1;
        end
    endfunction

    // Clear bit 0, then clamp to the legal Ethernet payload range
    function automatic logic [10:0] eff_len(input logic [10:0] len);
        logic [10:0] l;
        l = {len[10:1], 1'b0};
        if (l < 11'd46) begin
            l = 11'd46;
        end else if (l > 11'd1500) begin
            l = 11'd1500;
        end else begin
            l = l;
        end
        return l;
    endfunction

    // Address words 0..5 of the header (broadcast dst, then our MAC)
    function automatic logic [15:0] hdr_word(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return 16'hFFFF;
            3'd3:             return g_src_mac[47:32];
            3'd4:             return g_src_mac[31:16];
            3'd5:             return g_src_mac[15:0];
            default:          return 16'h0000;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d, stb_q, stb_d, busy_q, busy_d;
    logic [1:0]         sel_q;
    logic [15:0]        dat_q, dat_d, lfsr_q, lfsr_d, seed_s;
    logic [9:0]         wcnt_q, wcnt_d;
    logic [10:0]        len_q, len_d;
    logic [15:0]        idx_q, idx_d, num_q, num_d, gap_q, gap_d;
    logic [11:0]        out_q, out_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [31:0]        frames_q, frames_d, errs_q, errs_d;
    logic               acc_s, in_frame_s, start_s, abort_s;

    assign acc_s      = stb_q & ~src_stall_i;
    assign in_frame_s = (state_q == S_HDR) || (state_q == S_PAY) || (state_q == S_WACK);
    assign seed_s     = cfg_seed_i + idx_d;

    // Next-state logic for the frame sequencer, counters and bus outputs
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        dat_d    = dat_q;
        wcnt_d   = wcnt_q;
        len_d    = len_q;
        lfsr_d   = lfsr_q;
        idx_d    = idx_q;
        num_d    = num_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        frames_d = frames_q;
        errs_d   = errs_q;
        start_s  = 1'b0;
        abort_s  = 1'b0;

        // Outstanding acks: simultaneous accept and ack cancel out
        if (in_frame_s && acc_s && !src_ack_i) begin
            out_d = out_q + 12'd1;
        end else if (in_frame_s && !acc_s && src_ack_i && (out_q != 12'd0)) begin
            out_d = out_q - 12'd1;
        end else begin
            out_d = out_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_en_i) begin
                    idx_d   = 16'd0;
                    start_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (src_err_i) begin
                    abort_s = 1'b1;
                end else if (acc_s && (wcnt_q == 10'd6)) begin
                    state_d = S_PAY;
                    wcnt_d  = 10'd0;
                    dat_d   = lfsr_q;
                end else if (acc_s) begin
                    wcnt_d = wcnt_q + 10'd1;
                    dat_d  = (wcnt_q == 10'd5) ? {5'd0, len_q} : hdr_word(wcnt_q[2:0] + 3'd1);
                end else begin
                    dat_d = dat_q;
                end
            end
            S_PAY: begin
                if (src_err_i) begin
                    abort_s = 1'b1;
                end else if (acc_s) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    dat_d  = lfsr_step(lfsr_q);
                    if (wcnt_q == (len_q[10:1] - 10'd1)) begin
                        stb_d   = 1'b0;
                        tmo_d   = '0;
                        state_d = S_WACK;
                    end else begin
                        wcnt_d = wcnt_q + 10'd1;
                    end
                end else begin
                    dat_d = dat_q;
                end
            end
            S_WACK: begin
                if (src_err_i) begin
                    abort_s = 1'b1;
                end else if (out_q == 12'd0) begin
                    cyc_d    = 1'b0;
                    frames_d = frames_q + 32'd1;
                    idx_d    = idx_q + 16'd1;
                    gap_d    = (cfg_gap_i == 16'd0) ? 16'd1 : cfg_gap_i;
                    state_d  = S_GAP;
                end else if (src_ack_i) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q > 16'd1) begin
                    gap_d = gap_q - 16'd1;
                end else if ((num_q != 16'd0) && (idx_q == num_q)) begin
                    state_d = S_DONE;
                end else if (cfg_en_i) begin
                    start_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!cfg_en_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        // Abandon the current frame; the gap still applies before any restart
        if (abort_s) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            errs_d  = errs_q + 32'd1;
            out_d   = 12'd0;
            gap_d   = (cfg_gap_i == 16'd0) ? 16'd1 : cfg_gap_i;
            state_d = S_GAP;
        end else begin
            errs_d = errs_d;
        end

        // Frame start: sample configuration and present the first dst word
        if (start_s) begin
            state_d = S_HDR;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            dat_d   = 16'hFFFF;
            wcnt_d  = 10'd0;
            len_d   = eff_len(cfg_len_i);
            num_d   = cfg_num_i;
            out_d   = 12'd0;
            tmo_d   = '0;
            lfsr_d  = (seed_s == 16'd0) ? LFSR_INIT : seed_s;
        end else begin
            lfsr_d = lfsr_d;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            sel_q    <= 2'b00;
            dat_q    <= 16'h0000;
            wcnt_q   <= 10'd0;
            len_q    <= 11'd46;
            lfsr_q   <= LFSR_INIT;
            idx_q    <= 16'd0;
            num_q    <= 16'd0;
            gap_q    <= 16'd1;
            out_q    <= 12'd0;
            tmo_q    <= '0;
            frames_q <= 32'd0;
            errs_q   <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            sel_q    <= 2'b11;
            dat_q    <= dat_d;
            wcnt_q   <= wcnt_d;
            len_q    <= len_d;
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            gap_q    <= gap_d;
            out_q    <= out_d;
            tmo_q    <= tmo_d;
            frames_q <= frames_d;
            errs_q   <= errs_d;
            busy_q   <= busy_d;
        end
    end

    assign src_cyc_o = cyc_q;
    assign src_stb_o = stb_q;
    assign src_we_o  = cyc_q;
    assign src_adr_o = 2'b00;
    assign src_sel_o = sel_q;
    assign src_dat_o = dat_q;
    assign busy_o    = busy_q;
    assign frames_o  = frames_q;
    assign errs_o    = errs_q;

endmodule
